clk_div_rst_seq: RTL and testbench
==================================

CLK_DIV_RST_SEQ -- requirements
Module: clk_div_rst_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of divided-enable/reset channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8, divisor width per channel.
REQ-003 SHALL have parameter DEF_DIV, default 1, divisor loaded into every channel at reset.
REQ-004 SHALL have parameter LOCK_CYCLES, default 256, consecutive synced-lock cycles required before lock is declared stable.
REQ-005 SHALL have parameter SEQ_GAP, default 16, cycles between consecutive channel reset releases.
REQ-006 SHALL have parameter SW_RST_CYCLES, default 4, length of a software-requested channel reset.
REQ-007 SHALL have port ref_clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-008 SHALL have port ext_rst, input, 1; reset is asynchronous and active-high.
REQ-009 SHALL have port pll_lock_i, input, 1, raw PLL lock, asynchronous to ref_clk.
REQ-010 SHALL have port div_i, input, NUM_CH*DIV_W, per-channel divisor; channel k uses bits [k*DIV_W +: DIV_W].
REQ-011 SHALL have port div_upd_i, input, 1, single-cycle pulse capturing div_i into the shadow registers.
REQ-012 SHALL have port ch_en_i, input, NUM_CH, per-channel run enable.
REQ-013 SHALL have port sw_rst_i, input, NUM_CH, per-channel software reset request pulse.
REQ-014 SHALL have port clk_en_o, output, NUM_CH, registered one-cycle clock-enable pulses.
REQ-015 SHALL have port clk_tgl_o, output, NUM_CH, registered square wave toggling on each clk_en_o pulse.
REQ-016 SHALL have port rst_o, output, NUM_CH, registered active-high channel resets.
REQ-017 SHALL have port pll_locked_o, output, 1, stable-lock status.
REQ-018 SHALL have port seq_done_o, output, 1, high when all channels are released and the FSM is in RUN.

Function
REQ-019 SHALL synchronise pll_lock_i through a 2-flop synchroniser before any use.
REQ-020 SHALL implement FSM states WAIT_LOCK, RELEASE, RUN; reset state WAIT_LOCK.
REQ-021 WAIT_LOCK: SHALL count consecutive cycles of synced lock high, clearing the count on any low cycle; on reaching LOCK_CYCLES SHALL set pll_locked_o and enter RELEASE with channel index 0.
REQ-022 RELEASE: SHALL deassert rst_o[idx], then wait SEQ_GAP cycles before releasing idx+1; after releasing channel NUM_CH-1 SHALL enter RUN and set seq_done_o the next cycle.
REQ-023 In any state other than WAIT_LOCK, synced lock low SHALL, on the next edge, assert all rst_o, clear pll_locked_o and seq_done_o, and return to WAIT_LOCK.
REQ-024 sw_rst_i[k] in RUN SHALL assert rst_o[k] for exactly SW_RST_CYCLES cycles starting next cycle; a repeat request during the hold SHALL restart the hold; requests outside RUN SHALL be ignored.
REQ-025 A divisor value of 0 SHALL be treated as 1.
REQ-026 Channel counter k SHALL run 0..N-1 while ch_en_i[k]=1 and rst_o[k]=0, else hold at 0.
REQ-027 clk_en_o[k] SHALL be high in the cycle after the counter equals N-1, giving one pulse every N cycles (continuous high for N=1); first pulse occurs N cycles after the counter starts.
REQ-028 clk_tgl_o[k] SHALL invert on each cycle clk_en_o[k] is high, giving period 2N.
REQ-029 Captured shadow divisor SHALL apply to a running channel only at its period boundary (counter = N-1); to an idle or reset channel on the next cycle.
REQ-030 div_upd_i coinciding with a period boundary SHALL apply the new value at the following boundary.
REQ-031 ch_en_i[k] deassertion SHALL zero the counter and clk_en_o[k] next cycle; clk_tgl_o[k] SHALL hold its value.

Reset
REQ-032 While ext_rst is high: rst_o all ones, clk_en_o, clk_tgl_o, pll_locked_o, seq_done_o zero, counters zero, shadows DEF_DIV, FSM WAIT_LOCK, lock synchroniser cleared.
REQ-033 rst_o[k] high SHALL force counter, clk_en_o[k] and clk_tgl_o[k] to zero.

Verification
REQ-034 Lock held high from reset release, defaults -> pll_locked_o rises 258 cycles after release (2 sync + 256), rst_o[0..3] fall at 16-cycle spacing, seq_done_o high after channel 3.
REQ-035 Lock glitches low for 1 cycle at count 200 -> count restarts, pll_locked_o delayed by 201+ cycles.
REQ-036 RUN, div_i ch0=4, div_upd_i, ch_en_i[0]=1 -> clk_en_o[0] pulses every 4 cycles, clk_tgl_o[0] period 8; change to 3 mid-period -> old period completes, then every 3.
REQ-037 Divisor 0 on ch1 -> clk_en_o[1] continuously high.
REQ-038 sw_rst_i[2] pulse in RUN -> rst_o[2] high exactly 4 cycles, other channels unaffected.
REQ-039 Lock drops in RUN -> all rst_o high 3 cycles later (2 sync + 1), seq_done_o low, full sequence repeats once lock returns.

Source files
------------

// File: rtl/clk_div_rst_seq.sv
// -----------------------------------------------------------------------------
// clk_div_rst_seq
//
// Purpose:
//   Waits for the PLL lock to be stable. Then it releases the per-channel
//   resets one channel at a time. For each channel it generates a divided
//   clock-enable pulse train and a square wave. Losing lock at any point after
//   lock was declared puts every channel back into reset and restarts the
//   whole sequence.
//
// Parameters:
//   NUM_CH        number of channels (1..16)
//   DIV_W         divisor width per channel
//   DEF_DIV       divisor loaded into every channel at reset
//   LOCK_CYCLES   consecutive synced-lock cycles needed to declare lock stable
//   SEQ_GAP       cycles between consecutive channel reset releases
//   SW_RST_CYCLES length of a software-requested channel reset
//
// Ports:
//   ref_clk       single clock, rising edge
//   ext_rst       asynchronous active-high reset
//   pll_lock_i    raw PLL lock (asynchronous to ref_clk)
//   div_i         per-channel divisor, channel k at [k*DIV_W +: DIV_W]
//   div_upd_i     one-cycle pulse that captures div_i into the shadow registers
//   ch_en_i       per-channel run enable
//   sw_rst_i      per-channel software reset request pulse
//   clk_en_o      one-cycle clock-enable pulse every N cycles per channel
//   clk_tgl_o     square wave that toggles on each clk_en_o pulse (period 2N)
//   rst_o         active-high channel resets
//   pll_locked_o  lock has been stable for LOCK_CYCLES cycles
//   seq_done_o    all channels released and the sequencer is running
// -----------------------------------------------------------------------------
module clk_div_rst_seq #(
    parameter int NUM_CH        = 4,
    parameter int DIV_W         = 8,
    parameter int DEF_DIV       = 1,
    parameter int LOCK_CYCLES   = 256,
    parameter int SEQ_GAP       = 16,
    parameter int SW_RST_CYCLES = 4
) (
    input  logic                    ref_clk,
    input  logic                    ext_rst,
    input  logic                    pll_lock_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic                    div_upd_i,
    input  logic [NUM_CH-1:0]       ch_en_i,
    input  logic [NUM_CH-1:0]       sw_rst_i,
    output logic [NUM_CH-1:0]       clk_en_o,
    output logic [NUM_CH-1:0]       clk_tgl_o,
    output logic [NUM_CH-1:0]       rst_o,
    output logic                    pll_locked_o,
    output logic                    seq_done_o
);

    localparam int LOCK_W = (LOCK_CYCLES   > 1) ? $clog2(LOCK_CYCLES)   : 1;
    localparam int GAP_W  = (SEQ_GAP       > 1) ? $clog2(SEQ_GAP)       : 1;
    localparam int HOLD_W = (SW_RST_CYCLES > 1) ? $clog2(SW_RST_CYCLES) : 1;
    localparam int IDX_W  = (NUM_CH        > 1) ? $clog2(NUM_CH)        : 1;

    // Terminal values of the down/up counters (count to "last", not to N)
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SEQ_GAP - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SW_RST_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);
    localparam logic [DIV_W-1:0]  DEF_DIV_V = DIV_W'(DEF_DIV);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN
    } state_t;

    // -------------------------------------------------------------------------
    // Lock synchroniser
    // -------------------------------------------------------------------------
    logic lock_meta_q;
    logic lock_sync_q;

    always_ff @(posedge ref_clk or posedge ext_rst) begin
        if (ext_rst) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_sync_q <= lock_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Lock qualification and reset release sequencer
    // -------------------------------------------------------------------------
    state_t             state_q;
    logic [LOCK_W-1:0]  lock_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_CH-1:0]  rst_q;
    logic [HOLD_W-1:0]  hold_cnt_q [NUM_CH];
    logic               locked_q;
    logic               done_q;

    always_ff @(posedge ref_clk or posedge ext_rst) begin
        if (ext_rst) begin
            state_q    <= ST_WAIT_LOCK;
            lock_cnt_q <= '0;
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            rst_q      <= '1;
            locked_q   <= 1'b0;
            done_q     <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                hold_cnt_q[k] <= '0;
            end
        end else if ((state_q != ST_WAIT_LOCK) && !lock_sync_q) begin
            // Lock lost after it was declared: everything back into reset
            state_q    <= ST_WAIT_LOCK;
            lock_cnt_q <= '0;
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            rst_q      <= '1;
            locked_q   <= 1'b0;
            done_q     <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                hold_cnt_q[k] <= '0;
            end
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (!lock_sync_q) begin
                        lock_cnt_q <= '0;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        // This is the LOCK_CYCLES-th consecutive high cycle
                        locked_q   <= 1'b1;
                        state_q    <= ST_RELEASE;
                        lock_cnt_q <= '0;
                        idx_q      <= '0;
                        gap_cnt_q  <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end else begin
                        rst_q[idx_q] <= 1'b0;
                        gap_cnt_q    <= GAP_LAST;
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_RUN;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    done_q <= 1'b1;
                    // Software resets: a new request restarts the hold
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (sw_rst_i[k]) begin
                            rst_q[k]      <= 1'b1;
                            hold_cnt_q[k] <= HOLD_LAST;
                        end else if (rst_q[k]) begin
                            if (hold_cnt_q[k] == '0) begin
                                rst_q[k] <= 1'b0;
                            end else begin
                                hold_cnt_q[k] <= hold_cnt_q[k] - 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

    assign rst_o        = rst_q;
    assign pll_locked_o = locked_q;
    assign seq_done_o   = done_q;

    // -------------------------------------------------------------------------
    // Per-channel divider
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] shadow_q;
            logic [DIV_W-1:0] act_q;
            logic [DIV_W-1:0] cnt_q;
            logic             en_q;
            logic             tgl_q;
            logic [DIV_W-1:0] last_cnt;
            logic             ch_run;
            logic             boundary;
            logic             en_d;

            // A divisor of 0 behaves like 1, so the last count is 0 in both cases
            assign last_cnt = (act_q == '0) ? '0 : (act_q - 1'b1);
            assign ch_run   = ch_en_i[gi] & ~rst_q[gi];
            assign boundary = (cnt_q == last_cnt);
            assign en_d     = ch_run & boundary;

            always_ff @(posedge ref_clk or posedge ext_rst) begin
                if (ext_rst) begin
                    shadow_q <= DEF_DIV_V;
                    act_q    <= DEF_DIV_V;
                    cnt_q    <= '0;
                    en_q     <= 1'b0;
                    tgl_q    <= 1'b0;
                end else begin
                    if (div_upd_i) begin
                        shadow_q <= div_i[gi*DIV_W +: DIV_W];
                    end
                    // Idle channels track the shadow directly. Running channels
                    // only pick it up at the end of a period. An update landing
                    // on a boundary is still in flight here and waits one period.
                    if (!ch_run || boundary) begin
                        act_q <= shadow_q;
                    end
                    cnt_q <= (ch_run && !boundary) ? (cnt_q + 1'b1) : '0;
                    en_q  <= en_d;
                    tgl_q <= rst_q[gi] ? 1'b0 : (tgl_q ^ en_d);
                end
            end

            assign clk_en_o[gi]  = en_q;
            assign clk_tgl_o[gi] = tgl_q;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_clk_div_rst_seq
//
// Directed and randomised bench for clk_div_rst_seq.
// - Lock qualification timing: the expected edges are derived from where the
//   raw lock was last low.
// - Reset release staircase and seq_done timing.
// - The divider, toggle and software-reset behaviour are checked against a
//   timestamp model. The model predicts the edge of each next pulse, not a
//   counter value.
// - Lock loss in RUN and the full resequencing that follows.
// -----------------------------------------------------------------------------
module tb_clk_div_rst_seq;

    localparam int NUM_CH        = 4;
    localparam int DIV_W         = 8;
    localparam int DEF_DIV       = 1;
    localparam int LOCK_CYCLES   = 256;
    localparam int SEQ_GAP       = 16;
    localparam int SW_RST_CYCLES = 4;
    localparam logic [NUM_CH-1:0] ALL1 = '1;

    logic                    ref_clk = 1'b0;
    logic                    ext_rst;
    logic                    pll_lock_i;
    logic [NUM_CH*DIV_W-1:0] div_i;
    logic                    div_upd_i;
    logic [NUM_CH-1:0]       ch_en_i;
    logic [NUM_CH-1:0]       sw_rst_i;
    logic [NUM_CH-1:0]       clk_en_o;
    logic [NUM_CH-1:0]       clk_tgl_o;
    logic [NUM_CH-1:0]       rst_o;
    logic                    pll_locked_o;
    logic                    seq_done_o;

    int checks = 0;
    int errors = 0;

    clk_div_rst_seq #(
        .NUM_CH       (NUM_CH),
        .DIV_W        (DIV_W),
        .DEF_DIV      (DEF_DIV),
        .LOCK_CYCLES  (LOCK_CYCLES),
        .SEQ_GAP      (SEQ_GAP),
        .SW_RST_CYCLES(SW_RST_CYCLES)
    ) dut (
        .ref_clk     (ref_clk),
        .ext_rst     (ext_rst),
        .pll_lock_i  (pll_lock_i),
        .div_i       (div_i),
        .div_upd_i   (div_upd_i),
        .ch_en_i     (ch_en_i),
        .sw_rst_i    (sw_rst_i),
        .clk_en_o    (clk_en_o),
        .clk_tgl_o   (clk_tgl_o),
        .rst_o       (rst_o),
        .pll_locked_o(pll_locked_o),
        .seq_done_o  (seq_done_o)
    );

    always #5 ref_clk = ~ref_clk;

    // -------------------------------------------------------------------------
    // Channel reference model. Active only while the sequencer is known to be
    // in RUN. Each channel remembers the edge on which its next pulse is due.
    // -------------------------------------------------------------------------
    int                cyc = 0;
    logic              model_on = 1'b0;
    logic [NUM_CH-1:0] m_en  = '0;
    logic [NUM_CH-1:0] m_tgl = '0;
    int                m_hold   [NUM_CH];
    int                m_next   [NUM_CH];
    int                m_shadow [NUM_CH];
    int                q0[$];

    function automatic int eff_div(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [NUM_CH-1:0] m_rst_vec();
        logic [NUM_CH-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k] = (m_hold[k] != 0);
        return v;
    endfunction

    initial begin
        for (int k = 0; k < NUM_CH; k++) begin
            m_hold[k] = 0;
            m_next[k] = 0;
            m_shadow[k] = DEF_DIV;
        end
    end

    always @(posedge ref_clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ext_rst) m_shadow[k] <= DEF_DIV;
            else if (div_upd_i) m_shadow[k] <= int'(div_i[k*DIV_W +: DIV_W]);

            if (!model_on) begin
                m_en[k]   <= 1'b0;
                m_tgl[k]  <= 1'b0;
                m_hold[k] <= 0;
                m_next[k] <= 0;
            end else begin
                if (sw_rst_i[k]) m_hold[k] <= SW_RST_CYCLES;
                else if (m_hold[k] > 0) m_hold[k] <= m_hold[k] - 1;

                if (ch_en_i[k] && (m_hold[k] == 0)) begin
                    if (cyc == m_next[k]) begin
                        m_en[k]   <= 1'b1;
                        m_tgl[k]  <= ~m_tgl[k];
                        m_next[k] <= cyc + eff_div(m_shadow[k]);
                    end else begin
                        m_en[k] <= 1'b0;
                    end
                end else begin
                    // Stopped: if it runs from the next edge, its first pulse is N edges out
                    m_en[k]   <= 1'b0;
                    m_next[k] <= cyc + eff_div(m_shadow[k]);
                    if (m_hold[k] != 0) m_tgl[k] <= 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    task automatic step();
        @(posedge ref_clk);
        #1;
        if (clk_en_o[0]) q0.push_back(cyc);
        if (model_on) begin
            chk("model_clk_en", 32'(clk_en_o), 32'(m_en));
            chk("model_clk_tgl", 32'(clk_tgl_o), 32'(m_tgl));
            chk("model_rst", 32'(rst_o), 32'(m_rst_vec()));
        end
    endtask

    task automatic set_div(input int k, input int v);
        div_i[k*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    // Edge 0 is the current edge. The raw lock is high from here on, and the
    // synchroniser holds 0. A glitch drives the raw lock low for one cycle
    // after edge 'glitch'.
    task automatic bring_up(input int glitch);
        int lk;
        int dn;
        int exp_lk;
        int rel [NUM_CH];
        lk = -1;
        dn = -1;
        for (int i = 0; i < NUM_CH; i++) rel[i] = -1;
        for (int e = 1; e <= 1000 && dn < 0; e++) begin
            step();
            if (glitch > 0 && e == glitch) pll_lock_i = 1'b0;
            if (glitch > 0 && e == glitch + 1) pll_lock_i = 1'b1;
            if (lk < 0 && pll_locked_o) lk = e;
            for (int i = 0; i < NUM_CH; i++) if (rel[i] < 0 && !rst_o[i]) rel[i] = e;
            if (dn < 0 && seq_done_o) dn = e;
        end
        // The last low raw sample, plus LOCK_CYCLES good samples, plus 2 sync stages
        exp_lk = (glitch > 0) ? (glitch + 1 + LOCK_CYCLES + 2) : (LOCK_CYCLES + 2);
        chk("lock_edge", lk, exp_lk);
        for (int i = 0; i < NUM_CH; i++)
            chk($sformatf("release_edge_ch%0d", i), rel[i], exp_lk + 1 + SEQ_GAP * i);
        chk("seq_done_edge", dn, exp_lk + 1 + SEQ_GAP * (NUM_CH - 1) + 1);
        $display("bring_up glitch=%0d lock_edge=%0d done_edge=%0d", glitch, lk, dn);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int glitch;
        int c0;
        int p;
        logic [7:0]        pat;
        logic [NUM_CH-1:0] others;

        ext_rst    = 1'b1;
        pll_lock_i = 1'b0;
        div_i      = '0;
        div_upd_i  = 1'b0;
        ch_en_i    = '0;
        sw_rst_i   = '0;
        repeat (3) step();

        chk("reset_rst", 32'(rst_o), 32'(ALL1));
        chk("reset_clk_en", 32'(clk_en_o), 0);
        chk("reset_clk_tgl", 32'(clk_tgl_o), 0);
        chk("reset_locked", 32'(pll_locked_o), 0);
        chk("reset_done", 32'(seq_done_o), 0);

        // The lock glitches low for one cycle at a count of about 200
        glitch     = $urandom_range(195, 210);
        pll_lock_i = 1'b1;
        ext_rst    = 1'b0;
        bring_up(glitch);

        // Asynchronous reset in the middle of a cycle, with no clock edge
        #2 ext_rst = 1'b1;
        #1;
        chk("async_rst_rst", 32'(rst_o), 32'(ALL1));
        chk("async_rst_locked", 32'(pll_locked_o), 0);
        chk("async_rst_done", 32'(seq_done_o), 0);
        step();
        step();

        // Lock stays clean from the release of reset
        ext_rst = 1'b0;
        bring_up(0);

        // Divider: ch0 divides by 4, ch1 by 0 (treated as 1), ch2 and ch3 by 2
        model_on = 1'b1;
        step();
        set_div(0, 4);
        set_div(1, 0);
        set_div(2, 2);
        set_div(3, 2);
        div_upd_i = 1'b1;
        step();
        div_upd_i = 1'b0;
        step();
        step();
        ch_en_i = 4'b0011;
        c0 = cyc;
        q0.delete();
        for (int i = 0; i < 17; i++) begin
            step();
            if (i >= 1) chk("ch1_div0_en", 32'(clk_en_o[1]), 1);
        end
        chk("ch0_pulse_count", q0.size(), 4);
        if (q0.size() >= 4) begin
            chk("ch0_first_pulse", q0[0] - c0, 4);
            for (int i = 0; i < 3; i++) chk("ch0_period4", q0[i+1] - q0[i], 4);
        end
        $display("ch0 div4 pulses=%0d", q0.size());

        // Change to 3 mid-period: the old period of 4 completes, then periods of 3
        q0.delete();
        for (int i = 0; i < 8 && q0.size() == 0; i++) step();
        chk("ch0_pulse_seen", q0.size(), 1);
        step();
        set_div(0, 3);
        div_upd_i = 1'b1;
        step();
        div_upd_i = 1'b0;
        repeat (10) step();
        chk("ch0_change_pulses", q0.size(), 4);
        if (q0.size() >= 4) begin
            chk("ch0_old_period", q0[1] - q0[0], 4);
            chk("ch0_new_period_a", q0[2] - q0[1], 3);
            chk("ch0_new_period_b", q0[3] - q0[2], 3);
        end
        $display("ch0 div change 4->3 pulses=%0d", q0.size());

        // A software reset on channel 2 holds for 4 cycles and leaves the others alone
        ch_en_i = '1;
        repeat (3) step();
        sw_rst_i = 4'b0100;
        step();
        sw_rst_i = '0;
        pat    = '0;
        others = '0;
        pat[0] = rst_o[2];
        others = others | (rst_o & 4'b1011);
        for (int j = 1; j < 8; j++) begin
            step();
            pat[j] = rst_o[2];
            others = others | (rst_o & 4'b1011);
        end
        chk("sw_rst_pattern", 32'(pat), 32'h0F);
        chk("sw_rst_others", 32'(others), 0);
        $display("sw_rst ch2 pattern=%b", pat);

        // Random phase: enables, divisor updates and software resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) ch_en_i = NUM_CH'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < NUM_CH; k++) set_div(k, $urandom_range(0, 7));
                div_upd_i = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) sw_rst_i[$urandom_range(0, NUM_CH - 1)] = 1'b1;
            step();
            div_upd_i = 1'b0;
            sw_rst_i  = '0;
        end
        chk("run_locked", 32'(pll_locked_o), 1);
        chk("run_done", 32'(seq_done_o), 1);
        $display("random phase done checks=%0d", checks);

        // The lock drops in RUN: all resets rise 3 edges later
        ch_en_i = '0;
        repeat (8) step();
        model_on   = 1'b0;
        pll_lock_i = 1'b0;
        step();
        chk("drop_e1_rst", 32'(rst_o), 0);
        step();
        chk("drop_e2_rst", 32'(rst_o), 0);
        step();
        chk("drop_e3_rst", 32'(rst_o), 32'(ALL1));
        chk("drop_e3_locked", 32'(pll_locked_o), 0);
        chk("drop_e3_done", 32'(seq_done_o), 0);
        repeat (5) step();
        chk("drop_wait_rst", 32'(rst_o), 32'(ALL1));

        // The lock returns and the full sequence repeats
        pll_lock_i = 1'b1;
        bring_up(0);

        model_on = 1'b1;
        step();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) ch_en_i = NUM_CH'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < NUM_CH; k++) set_div(k, $urandom_range(0, 5));
                div_upd_i = 1'b1;
            end
            step();
            div_upd_i = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
